// File: rtl/simon_sequence_player.sv
// Simon playback engine: shows a captured colour sequence as timed light pulses.
// Optional Abort input enabled by defining SIMON_PLAYER_ABORT_EN.
module simon_sequence_player #(
  parameter int MAX_STEPS = 10,
  parameter int ON_TICKS  = 25000000,
  parameter int GAP_TICKS = 12500000
) (
  input  logic                   Clk,
  input  logic                   Reset,
`ifdef SIMON_PLAYER_ABORT_EN
  input  logic                   Abort,
`endif
  input  logic                   Play,
  input  logic [3*MAX_STEPS-1:0] Colors,
  input  logic [3:0]             Count,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Light_R,
  output logic                   Light_B,
  output logic                   Light_Y,
  output logic                   Light_G,
  output logic [3:0]             Step_Idx,
  output logic                   Err
);

  localparam int MAX_T = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int TW    = $clog2(MAX_T) + 1;
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);
  localparam logic [3:0]    MAX_CNT  = 4'(MAX_STEPS);

  typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

  state_t                 state, state_d;
  logic [TW-1:0]          timer, timer_d;
  logic [3:0]             step, step_d;
  logic [3:0]             count_q, count_d;
  logic [3*MAX_STEPS-1:0] colors_q, colors_d;
  logic                   abort_req;

  logic       busy_d, done_d, err_d;
  logic [3:0] lights_d;
  logic [3:0] step_idx_d;
  logic [2:0] code_d;

`ifdef SIMON_PLAYER_ABORT_EN
  assign abort_req = Abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      timer    <= '0;
      step     <= '0;
      count_q  <= '0;
      colors_q <= '0;
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      step     <= step_d;
      count_q  <= count_d;
      colors_q <= colors_d;
    end
  end

  always_comb begin
    state_d  = state;
    timer_d  = timer + 1'b1;
    step_d   = step;
    count_d  = count_q;
    colors_d = colors_q;
    case (state)
      IDLE: begin
        timer_d = '0;
        if (Play) begin
          if (Count != 4'd0) begin
            colors_d = Colors;
            count_d  = (Count > MAX_CNT) ? MAX_CNT : Count;
            step_d   = '0;
            state_d  = SHOW;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHOW: begin
        if (timer == ON_LAST) begin
          timer_d = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (timer == GAP_LAST) begin
          timer_d = '0;
          if (step == count_q - 4'd1) begin
            state_d = DONE;
          end else begin
            step_d  = step + 4'd1;
            state_d = SHOW;
          end
        end
      end
      default: begin
        timer_d = '0;
        step_d  = '0;
        state_d = IDLE;
      end
    endcase
    // Abort wins over normal sequencing, but only while playback is active.
    if (abort_req && (state == SHOW || state == GAP)) begin
      state_d = IDLE;
      timer_d = '0;
      step_d  = '0;
    end
  end

  // Outputs are decoded from the next-state values so they can be registered
  // and still line up with the state they describe.
  always_comb begin
    code_d     = 3'(colors_d >> (3 * step_d));
    busy_d     = (state_d == SHOW) || (state_d == GAP);
    done_d     = (state_d == DONE);
    step_idx_d = busy_d ? step_d : 4'd0;
    lights_d   = 4'b0000;
    err_d      = Err;
    if (state == IDLE && Play) err_d = 1'b0;
    if (state_d == SHOW) begin
      case (code_d)
        3'd1:    lights_d = 4'b1000;
        3'd2:    lights_d = 4'b0100;
        3'd3:    lights_d = 4'b0010;
        3'd4:    lights_d = 4'b0001;
        default: err_d    = 1'b1;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Light_R  <= 1'b0;
      Light_B  <= 1'b0;
      Light_Y  <= 1'b0;
      Light_G  <= 1'b0;
      Step_Idx <= 4'd0;
      Err      <= 1'b0;
    end else begin
      Busy     <= busy_d;
      Done     <= done_d;
      Light_R  <= lights_d[3];
      Light_B  <= lights_d[2];
      Light_Y  <= lights_d[1];
      Light_G  <= lights_d[0];
      Step_Idx <= step_idx_d;
      Err      <= err_d;
    end
  end

endmodule

// File: tb/tb_simon_sequence_player.sv
// Scoreboard bench for simon_sequence_player with ON_TICKS=4, GAP_TICKS=2.
module tb_simon_sequence_player;

  localparam int MAX_STEPS = 10;
  localparam int ON_T      = 4;
  localparam int GAP_T     = 2;
  localparam int W         = 11;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   abort;
  logic                   play;
  logic [3*MAX_STEPS-1:0] colors;
  logic [3:0]             count;
  logic                   busy, done, light_r, light_b, light_y, light_g, err;
  logic [3:0]             step_idx;

  simon_sequence_player #(
    .MAX_STEPS(MAX_STEPS), .ON_TICKS(ON_T), .GAP_TICKS(GAP_T)
  ) dut (
    .Clk(clk),
    .Reset(reset),
`ifdef SIMON_PLAYER_ABORT_EN
    .Abort(abort),
`endif
    .Play(play),
    .Colors(colors),
    .Count(count),
    .Busy(busy),
    .Done(done),
    .Light_R(light_r),
    .Light_B(light_b),
    .Light_Y(light_y),
    .Light_G(light_g),
    .Step_Idx(step_idx),
    .Err(err)
  );

  always #5 clk = ~clk;

  // Word layout: {busy, done, R, B, Y, G, step_idx[3:0], err}
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  int         cyc;
  int         cut_at;
  logic       keep_err;
  logic       last_err;
  logic       model_err = 1'b0;
  logic       cut_seen;
  logic [W-1:0] cut_w;

  function automatic logic [3:0] lights_of(input logic [2:0] code);
    case (code)
      3'd1:    return 4'b1000;
      3'd2:    return 4'b0100;
      3'd3:    return 4'b0010;
      3'd4:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  // Pushes one expected cycle; from cut_at onward the outputs freeze at idle.
  task automatic entry(input logic b, input logic d, input logic [2:0] code,
                       input logic [3:0] idx, input logic e);
    logic [W-1:0] w;
    w = {b, d, lights_of(code), idx, e};
    if (cyc >= cut_at) begin
      if (!cut_seen) begin
        cut_w    = {10'b0, keep_err ? last_err : 1'b0};
        cut_seen = 1'b1;
      end
      w = cut_w;
    end else begin
      last_err = e;
    end
    exp_q.push_back(w);
    cyc++;
  endtask

  task automatic push_play(input logic [3*MAX_STEPS-1:0] cols, input int cnt,
                           input int cut, input logic keep);
    int         n;
    logic       e;
    logic [2:0] code;
    n        = (cnt > MAX_STEPS) ? MAX_STEPS : cnt;
    cut_at   = cut;
    keep_err = keep;
    cut_seen = 1'b0;
    cyc      = 0;
    entry(1'b0, 1'b0, 3'd0, 4'd0, model_err);
    e = 1'b0;
    for (int s = 0; s < n; s++) begin
      code = cols[3*s +: 3];
      if (code == 3'd0 || code > 3'd4) e = 1'b1;
      for (int t = 0; t < ON_T; t++)  entry(1'b1, 1'b0, code, 4'(s), e);
      for (int t = 0; t < GAP_T; t++) entry(1'b1, 1'b0, 3'd0, 4'(s), e);
    end
    entry(1'b0, 1'b1, 3'd0, 4'd0, e);
    entry(1'b0, 1'b0, 3'd0, 4'd0, e);
    entry(1'b0, 1'b0, 3'd0, 4'd0, e);
    model_err = cut_seen ? cut_w[0] : e;
  endtask

  // Starts a run: Play is high for the cycle before the sampling edge (cycle 0).
  task automatic start_play(input logic [3*MAX_STEPS-1:0] cols, input int cnt,
                            input int cut, input logic keep);
    @(posedge clk); #1;
    push_play(cols, cnt, cut, keep);
    colors = cols;
    count  = 4'(cnt);
    play   = 1'b1;
    @(posedge clk); #1;
    play   = 1'b0;
    colors = '1;
    count  = 4'd7;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 300;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expected cycles left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] exp_w, act_w;
    if (exp_q.size() != 0) begin
      exp_w = exp_q.pop_front();
      act_w = {busy, done, light_r, light_b, light_y, light_g, step_idx, err};
      checks++;
      if (act_w !== exp_w) begin
        errors++;
        $display("FAIL out_word @%0t: got busy/done/RBYG/idx/err=%b/%b/%b/%0d/%b required %b/%b/%b/%0d/%b",
                 $time, act_w[10], act_w[9], act_w[8:5], act_w[4:1], act_w[0],
                 exp_w[10], exp_w[9], exp_w[8:5], exp_w[4:1], exp_w[0]);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    abort  = 1'b0;
    play   = 1'b0;
    colors = '0;
    count  = 4'd0;

    // Reset state
    for (int i = 0; i < 3; i++) exp_q.push_back('0);
    wait_drain();
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic: RED, YELLOW, GREEN
    start_play({21'd0, 3'd4, 3'd3, 3'd1}, 3, 1000, 1'b0);
    wait_drain();

    // Empty count
    start_play({21'd0, 3'd4, 3'd3, 3'd1}, 0, 1000, 1'b0);
    wait_drain();

    // Count clamped to ten BLUE steps
    start_play({10{3'd2}}, 15, 1000, 1'b0);
    wait_drain();

    // Invalid code in step 1; Err sticks after Done
    start_play({24'd0, 3'd0, 3'd1}, 2, 1000, 1'b0);
    wait_drain();

    // Next Play clears Err
    start_play({21'd0, 3'd2, 3'd4, 3'd3}, 3, 1000, 1'b0);
    wait_drain();

    // Play in cycle 5 of a two-step run is ignored
    start_play({24'd0, 3'd2, 3'd4}, 2, 1000, 1'b0);
    repeat (4) @(posedge clk);
    #1 play = 1'b1;
    @(posedge clk);
    #1 play = 1'b0;
    wait_drain();

    // Reset in cycle 8 clears everything, including Err
    start_play({24'd0, 3'd0, 3'd3}, 2, 8, 1'b0);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_drain();

`ifdef SIMON_PLAYER_ABORT_EN
    // Invalid step 0 sets Err, then Abort in cycle 3 idles from cycle 4 keeping Err
    start_play({24'd0, 3'd1, 3'd7}, 2, 4, 1'b1);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simon_sequence_player.md
Name: simon_sequence_player

Overview:
Playback side of the Simon game: presents the stored colour sequence to the player, one colour at a time, as timed light pulses. The game state machine consumes buttons and compares them against the packed colour word; this block drives the four colour lights from the same packed word. It is started with a single Play pulse and reports completion with a one-cycle Done pulse, after which the game state machine moves to button input.

Parameters:
MAX_STEPS, 10, number of 3-bit colour slots in Colors.
ON_TICKS, 25000000, clock cycles each colour light is held on (minimum 1).
GAP_TICKS, 12500000, clock cycles all lights are off between colours (minimum 1).

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
Play  input  1  start request; sampled only in IDLE.
Colors  input  3*MAX_STEPS  packed sequence; step k is Colors[3k+2:3k]; 1=RED, 2=BLUE, 3=YELLOW, 4=GREEN.
Count  input  4  number of steps to play.
Busy  output  1  high while in SHOW or GAP.
Done  output  1  one-cycle pulse when playback ends.
Light_R, Light_B, Light_Y, Light_G  output  1 each  colour light drives; at most one is high at a time.
Step_Idx  output  4  index of the step being shown; 0 when idle.
Err  output  1  sticky flag: an invalid colour code was encountered; cleared by the next accepted Play.

Behaviour:
- Reset (asynchronous): state=IDLE; Busy, Done, all Lights, Err = 0; Step_Idx = 0; timer = 0.
- States: IDLE, SHOW, GAP, DONE. All outputs are registered.
- IDLE:
  - Play=1 with Count>=1: capture Colors and min(Count, MAX_STEPS) into internal registers; clear Err; set step=0.
  - On that same clock edge, go to SHOW. The first light is high in the cycle immediately after the edge that sampled Play.
  - Play=1 with Count=0: go to DONE; no lights are shown.
- SHOW:
  - Exactly one light is high for ON_TICKS cycles, chosen by the captured code for the current step.
  - Invalid code (0, 5, 6 or 7): all lights stay off for the slot and Err is set.
  - After ON_TICKS cycles, go to GAP.
- GAP:
  - All lights are off for GAP_TICKS cycles.
  - Then, if step is the last step, go to DONE; otherwise increment step and Step_Idx and go to SHOW.
- DONE: Done=1 and Busy=0 for one cycle; Step_Idx returns to 0; then go to IDLE.
- Timing: for an effective count N, Busy is high for exactly N*(ON_TICKS+GAP_TICKS) cycles, and Done rises in the cycle after Busy falls.
- Play asserted while in SHOW, GAP or DONE is ignored. Play is not queued.
- Changes on Colors or Count after capture have no effect until the next accepted Play.
- Play held high continuously: playback restarts on the first IDLE cycle after DONE.
- Reset asserted mid-playback: immediate return to IDLE with all outputs cleared; no Done pulse.
- Timer width is the ceiling of log2 of max(ON_TICKS, GAP_TICKS), plus 1. The timer counts up from 0 and is cleared on every state change.

Optional Feature:
SIMON_PLAYER_ABORT_EN:
- Defined: adds input port Abort (1 bit). Abort=1 in SHOW or GAP forces IDLE on the next edge: lights off, Busy=0, Step_Idx=0, no Done pulse, Err keeps its value. Abort in IDLE or DONE has no effect.
- Undefined: the port is absent and playback always runs to completion.

Test Plan:
All scenarios use ON_TICKS=4, GAP_TICKS=2.
- Basic sequence: Colors[8:0]=100_011_001 (RED, YELLOW, GREEN), Count=3, one-cycle Play -> Light_R high in cycles 1-4, off 5-6, Light_Y high 7-10, Light_G high 13-16; Busy high for 18 cycles; Done=1 in cycle 19 only; Err=0.
- Empty count: Count=0, Play -> no light ever high, Busy stays 0, Done=1 in cycle 1.
- Count clamp and full length: Count=15 with all ten codes set to 2 -> ten Light_B pulses; Step_Idx steps 0 through 9; Busy high for 60 cycles; then Done.
- Invalid code: step 1 code=0, Count=2 -> step 1 slot has all lights off and Err=1 from that slot onward; Err stays 1 after Done; the next Play clears Err.
- Play while busy: extra Play pulse in cycle 5 of a Count=2 run -> run still ends with Done at cycle 13 and no second playback starts.
- Reset and abort mid-run: Reset asserted in cycle 8 -> all outputs 0 at once and no Done pulse. With SIMON_PLAYER_ABORT_EN defined, Abort=1 in cycle 3 -> IDLE from cycle 4 with lights off and no Done pulse.
